// File: rtl/stu_num_scheduler_pkg.sv
// rtl/stu_num_scheduler_pkg.sv - shared encodings and helpers for the student-number display sequencer
package stu_num_scheduler_pkg;

    localparam int         BCD_W  = 4;
    localparam logic [3:0] AN_OFF = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCROLL = 2'd1,
        S_PAUSE  = 2'd2
    } state_e;

    // Nibble 0 is the most significant nibble of the 32-bit ID.
    function automatic logic [BCD_W-1:0] id_nibble(input logic [31:0] id, input logic [3:0] idx);
        logic [31:0] sh;
        sh = id << {idx[2:0], 2'b00};
        return sh[31:28];
    endfunction

endpackage

// File: rtl/stu_num_scheduler_tick_div.sv
// rtl/stu_num_scheduler_tick_div.sv - wrap counter with a registered one-cycle pulse
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active-high
//   wrap  out  combinational, high while the counter sits at DIV-1
//   pulse out  registered, high for the cycle after the counter wraps
module tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic wrap,
    output logic pulse
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          pulse_q;

    assign wrap  = (cnt_q == CW'(DIV - 1));
    assign pulse = pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
            pulse_q <= wrap;
        end
    end

endmodule

// File: rtl/stu_num_scheduler.sv
// rtl/stu_num_scheduler.sv - scrolls a BCD student number through a 4-digit multiplexed window
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-high
//   start    in   pulse: begin scrolling from offset 0
//   stop     in   pulse: return to idle, blank display
//   pause    in   level: freeze the scroll offset
//   p_500ms  out  one-cycle pulse every TICK_DIV clocks
//   display  out  active digit position, 0 = leftmost
//   digit    out  BCD value for the active position
//   an       out  digit enables, active-low
//   blank    out  1 = decoder drives all segments off
//   busy     out  1 while scrolling or paused
module stu_num_scheduler
    import stu_num_scheduler_pkg::*;
#(
    parameter int          TICK_DIV   = 25_000_000,
    parameter int          SCAN_DIV   = 50_000,
    parameter int          NUM_DIGITS = 8,
    parameter logic [31:0] STU_ID     = 32'h15071234
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic             p_500ms,
    output logic [1:0]       display,
    output logic [BCD_W-1:0] digit,
    output logic [3:0]       an,
    output logic             blank,
    output logic             busy
);

    logic tick_pulse, tick_wrap_unused;
    logic scan_wrap, scan_pulse_unused;

    tick_div #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .wrap  (tick_wrap_unused),
        .pulse (tick_pulse)
    );

    // Display steps on the wrap edge itself, so the combinational wrap is used here.
    tick_div #(.DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst   (rst),
        .wrap  (scan_wrap),
        .pulse (scan_pulse_unused)
    );

    state_e           state_q, state_d;
    logic [2:0]       offset_q, offset_d;
    logic [1:0]       display_q, display_d;
    logic [BCD_W-1:0] digit_q;
    logic [3:0]       an_q;
    logic             blank_q;
    logic             busy_q;
    logic [3:0]       win_sum;
    logic [3:0]       win_idx;

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        display_d = display_q + {1'b0, scan_wrap};

        if (stop) begin
            state_d  = S_IDLE;
            offset_d = '0;
        end else begin
            if (state_q == S_SCROLL && tick_pulse) begin
                offset_d = (offset_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : offset_q + 3'd1;
            end
            case (state_q)
                S_IDLE:   if (start)  state_d = S_SCROLL;
                S_SCROLL: if (pause)  state_d = S_PAUSE;
                S_PAUSE:  if (!pause) state_d = S_SCROLL;
                default:              state_d = S_IDLE;
            endcase
            if (start) begin
                offset_d = '0;
            end
        end

        // Window index from next-state values so digit lines up with the new display/offset.
        // Sum is at most 7+3, so a single conditional subtract implements the modulo.
        win_sum = {1'b0, offset_d} + {2'b00, display_d};
        win_idx = (win_sum >= 4'(NUM_DIGITS)) ? win_sum - 4'(NUM_DIGITS) : win_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            offset_q  <= '0;
            display_q <= '0;
            digit_q   <= '0;
            an_q      <= AN_OFF;
            blank_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            display_q <= display_d;
            digit_q   <= id_nibble(STU_ID, win_idx);
            an_q      <= (state_d == S_IDLE) ? AN_OFF : ~(4'b0001 << display_d);
            blank_q   <= (state_d == S_IDLE);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign p_500ms = tick_pulse;
    assign display = display_q;
    assign digit   = digit_q;
    assign an      = an_q;
    assign blank   = blank_q;
    assign busy    = busy_q;

endmodule
